hazard_unit_pipe: RTL

- Parametrised successor to the single-stage forwarding controller.
- Resolves data hazards for the 5-stage pipeline (F, D, E, M, W) using:
  - two-level forwarding (M and W) into the D and E stages;
  - load-use stall detection;
  - a multi-cycle multiply/divide busy interlock;
  - branch flush and memory-freeze arbitration.
- Also keeps a saturating stall-cycle performance counter.
- Sits beside the datapath and drives its mux selects and pipeline-register enables/clears.

---
 rtl/hazard_unit_pipe_if.sv | 41 ++++
 rtl/hazard_unit_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/hazard_unit_pipe_if.sv
// rtl/hazard_unit_pipe_if.sv - hazard unit signal bundle between datapath and controller
//
// Purpose: groups every pipeline-side signal of the hazard unit so the
// datapath (master) and the hazard controller (slave) connect with one port.
// Ports (master drives / slave drives):
//   master -> slave : rsD, rtD, useRsD, useRtD, mdUseD, rsE, rtE, waE,
//                     regWriteE, memReadE, mdStartE, branchTakenE,
//                     waM, regWriteM, waW, regWriteW, memBusy
//   slave -> master : fwdAD, fwdBD, fwdAE, fwdBE, stallF, stallD,
//                     flushD, flushE, freeze, mdBusy, stallCnt
interface hazard_unit_pipe_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 32
);
   logic [AW-1:0]    rsD, rtD;
   logic             useRsD, useRtD, mdUseD;
   logic [AW-1:0]    rsE, rtE, waE;
   logic             regWriteE, memReadE, mdStartE, branchTakenE;
   logic [AW-1:0]    waM, waW;
   logic             regWriteM, regWriteW;
   logic             memBusy;
   logic [1:0]       fwdAD, fwdBD, fwdAE, fwdBE;
   logic             stallF, stallD, flushD, flushE, freeze, mdBusy;
   logic [CNT_W-1:0] stallCnt;

   modport master (
      output rsD, rtD, useRsD, useRtD, mdUseD, rsE, rtE, waE,
             regWriteE, memReadE, mdStartE, branchTakenE,
             waM, regWriteM, waW, regWriteW, memBusy,
      input  fwdAD, fwdBD, fwdAE, fwdBE, stallF, stallD,
             flushD, flushE, freeze, mdBusy, stallCnt
   );

   modport slave (
      input  rsD, rtD, useRsD, useRtD, mdUseD, rsE, rtE, waE,
             regWriteE, memReadE, mdStartE, branchTakenE,
             waM, regWriteM, waW, regWriteW, memBusy,
      output fwdAD, fwdBD, fwdAE, fwdBE, stallF, stallD,
             flushD, flushE, freeze, mdBusy, stallCnt
   );
endinterface

// File: rtl/hazard_unit_pipe.sv
// rtl/hazard_unit_pipe.sv - 5-stage pipeline hazard controller with forwarding and md interlock
//
// Purpose: drives forwarding mux selects and pipeline-register stall/flush/
// freeze controls, tracks the in-flight multiply/divide and counts stall cycles.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   hz    : hazard_unit_pipe_if.slave bundle (datapath inputs, control outputs)
// Parameters: AW register address width, MD_LAT mult/div latency (>=1),
//             CNT_W stall counter width (must match the interface).
module hazard_unit_pipe #(
   parameter int AW     = 5,
   parameter int MD_LAT = 32,
   parameter int CNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_unit_pipe_if.slave  hz
);
   localparam int             MDW     = $clog2(MD_LAT + 1);
   localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT);

   logic [MDW-1:0]   r_md_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_md_busy;
   logic w_load_use;
   logic w_md_haz;
   logic w_stall;
   logic w_flush_d;
   logic w_flush_e;
   logic w_freeze;

   // M wins over W; register 0 is hardwired so it is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] src,
      input logic [AW-1:0] wa_m,
      input logic          we_m,
      input logic [AW-1:0] wa_w,
      input logic          we_w
   );
      if (we_m && (wa_m != '0) && (wa_m == src))
         return 2'b10;
      else if (we_w && (wa_w != '0) && (wa_w == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign hz.fwdAD = fwd_sel(hz.rsD, hz.waM, hz.regWriteM, hz.waW, hz.regWriteW);
   assign hz.fwdBD = fwd_sel(hz.rtD, hz.waM, hz.regWriteM, hz.waW, hz.regWriteW);
   assign hz.fwdAE = fwd_sel(hz.rsE, hz.waM, hz.regWriteM, hz.waW, hz.regWriteW);
   assign hz.fwdBE = fwd_sel(hz.rtE, hz.waM, hz.regWriteM, hz.waW, hz.regWriteW);

   assign w_md_busy = (r_md_cnt != '0);

   always_comb begin
      w_load_use = hz.memReadE && hz.regWriteE && (hz.waE != '0) &&
                   ((hz.useRsD && (hz.waE == hz.rsD)) ||
                    (hz.useRtD && (hz.waE == hz.rtD)));
      w_md_haz   = hz.mdUseD && w_md_busy;
      w_stall    = 1'b0;
      w_flush_d  = 1'b0;
      w_flush_e  = 1'b0;
      w_freeze   = 1'b0;
      if (!rst_n) begin
         // Fill the pipe with bubbles while reset is held.
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (hz.memBusy) begin
         w_freeze  = 1'b1;
      end else if (hz.branchTakenE) begin
         // The stalled D instruction is on the wrong path, so it is squashed
         // instead of waited for.
         w_flush_d = 1'b1;
         w_flush_e = 1'b1;
      end else if (w_load_use || w_md_haz) begin
         w_stall   = 1'b1;
         w_flush_e = 1'b1;
      end
   end

   assign hz.stallF   = w_stall;
   assign hz.stallD   = w_stall;
   assign hz.flushD   = w_flush_d;
   assign hz.flushE   = w_flush_e;
   assign hz.freeze   = w_freeze;
   assign hz.mdBusy   = w_md_busy;
   assign hz.stallCnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_md_cnt    <= '0;
         r_stall_cnt <= '0;
      end else begin
         // A start issued under freeze never leaves E, so it must not load;
         // an operation already running keeps counting through the freeze.
         if (hz.mdStartE && !hz.memBusy)
            r_md_cnt <= MD_LOAD;
         else if (w_md_busy)
            r_md_cnt <= r_md_cnt - MDW'(1);

         if ((w_stall || w_freeze) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end
endmodule
